// File: rtl/cpu_cache_wt.sv
// Write-through, direct-mapped, one-word-line cache between the core memory
// port and the system bus. Read hits in the cacheable region complete with
// zero wait states; misses, uncached reads and all writes go to the bus.
//
// state  | meaning
// S_IDLE | accept CPU strobes, serve hits combinationally
// S_REQ  | one-cycle bus strobe for the latched request
// S_WAIT | bus strobe low, holding address/data until mem_ready
module cpu_cache_wt #(
  parameter int          IDX_W      = 6,
  parameter logic [31:0] CACHE_BASE = 32'h2000_0000,
  parameter logic [31:0] CACHE_MASK = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready,
  input  logic        flush,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [31:0] mem_spo,
  input  logic        mem_ready
);

  localparam int NLINES = 1 << IDX_W;
  localparam int TAG_W  = 30 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [NLINES-1:0]  valid_q;
  logic [TAG_W-1:0]   line_tag_q  [NLINES];
  logic [31:0]        line_data_q [NLINES];
  logic [31:0]        addr_q, data_q, resp_q;
  logic               is_wr_q, cacheable_q, flush_pend_q;

  logic [IDX_W-1:0]   cpu_idx, req_idx;
  logic [TAG_W-1:0]   cpu_tag, req_tag;
  logic               cpu_cacheable, hit;
  logic               start, complete;

  assign cpu_idx       = a[IDX_W+1:2];
  assign cpu_tag       = a[31:IDX_W+2];
  assign req_idx       = addr_q[IDX_W+1:2];
  assign req_tag       = addr_q[31:IDX_W+2];
  assign cpu_cacheable = ((a & CACHE_MASK) == CACHE_BASE);
  assign hit           = cpu_cacheable && valid_q[cpu_idx] && (line_tag_q[cpu_idx] == cpu_tag);

  // The bus address/data simply mirror the latched request; they hold through WAIT.
  assign mem_a = addr_q;
  assign mem_d = data_q;

  // Next-state and CPU/bus handshake decode.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    spo      = resp_q;
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    start    = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (we || (rd && !hit)) begin
          start   = 1'b1;
          state_d = S_REQ;
        end else begin
          ready = 1'b1;
          if (hit) spo = line_data_q[cpu_idx];
        end
      end
      S_REQ: begin
        mem_rd = !is_wr_q;
        mem_we = is_wr_q;
        if (mem_ready) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any bus transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Request latch, response register, valid bits and deferred flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      data_q       <= '0;
      is_wr_q      <= 1'b0;
      cacheable_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      resp_q       <= '0;
      valid_q      <= '0;
    end else begin
      if (start) begin
        addr_q       <= a;
        data_q       <= d;
        is_wr_q      <= we;
        cacheable_q  <= cpu_cacheable;
        flush_pend_q <= flush;
      end else if (state_q != S_IDLE && flush) begin
        flush_pend_q <= 1'b1;
      end
      if (complete) begin
        resp_q       <= is_wr_q ? data_q : mem_spo;
        flush_pend_q <= 1'b0;
        if (!is_wr_q && cacheable_q) valid_q[req_idx] <= 1'b1;
      end
      // A flush seen during the miss wins over the fill made on the same edge.
      if ((complete && (flush_pend_q || flush)) || (state_q == S_IDLE && flush && !start))
        valid_q <= '0;
    end
  end

  // Line tag/data storage: fill on read miss, update on write hit only.
  always_ff @(posedge clk) begin
    if (complete && cacheable_q) begin
      if (!is_wr_q) begin
        line_tag_q[req_idx]  <= req_tag;
        line_data_q[req_idx] <= mem_spo;
      end else if (valid_q[req_idx] && line_tag_q[req_idx] == req_tag) begin
        line_data_q[req_idx] <= data_q;
      end
    end
  end

endmodule
